servo_pwm_driver: RTL and testbench

Three-channel hobby-servo PWM generator for the arm. It consumes the 8-bit x/y/z position codes produced by the arm's accelerometer/ROM source-select FSM and drives one pulse per channel per 20 ms frame. Pulse width is linear in the position code. New codes are accepted only at frame boundaries, so a servo never sees a truncated or stretched pulse.

---
 rtl/servo_pwm_driver.sv | 124 ++++++++++++
 tb/tb_servo_pwm_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_driver.sv
// Three-channel hobby-servo PWM generator: one pulse per channel per frame, codes latched at frame boundaries.
// Optional per-frame slew limiting of the latched codes is enabled by defining SERVO_SLEW_LIMIT_EN.
module servo_pwm_driver #(
    parameter int TICK_DIV  = 50,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int STEP_US   = 4,
    parameter int SLEW_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] pos_x,
    input  logic [7:0] pos_y,
    input  logic [7:0] pos_z,
    output logic       pwm_x,
    output logic       pwm_y,
    output logic       pwm_z,
    output logic       frame_start
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [15:0]      FRAME_LAST = 16'(FRAME_US - 1);

    typedef enum logic [1:0] {SYNC, RUN, HOLD} phase_t;

    phase_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_cnt_next;
    logic [15:0]      frame_cnt, frame_cnt_next;
    logic [2:0][7:0]  pos, act, act_next;
    logic [2:0]       pwm, pwm_next;
    logic             run, run_next;
    logic             tick, boundary;

    assign pos = {pos_z, pos_y, pos_x};
    assign {pwm_z, pwm_y, pwm_x} = pwm;

    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (frame_cnt == FRAME_LAST);

    // Widths are capped one tick short of the frame so every frame keeps a low gap.
    function automatic logic [15:0] width_of(input logic [7:0] code);
        logic [31:0] w;
        w = 32'(MIN_US) + 32'(code) * 32'(STEP_US);
        if (w > 32'(FRAME_US - 1))
            return FRAME_LAST;
        return w[15:0];
    endfunction

`ifdef SERVO_SLEW_LIMIT_EN
    function automatic logic [7:0] next_code(input logic [7:0] cur, input logic [7:0] target);
        logic signed [8:0] diff;
        diff = $signed({1'b0, target}) - $signed({1'b0, cur});
        if (diff > $signed(9'(SLEW_STEP)))
            return cur + 8'(SLEW_STEP);
        else if (diff < -$signed(9'(SLEW_STEP)))
            return cur - 8'(SLEW_STEP);
        return target;
    endfunction
`else
    logic slew_unused;
    assign slew_unused = |32'(SLEW_STEP);

    function automatic logic [7:0] next_code(input logic [7:0] cur, input logic [7:0] target);
        logic [7:0] keep;
        keep = cur;
        keep = target;
        return keep;
    endfunction
`endif

    always_comb begin
        div_cnt_next = tick ? '0 : div_cnt + 1'b1;
        if (boundary)
            frame_cnt_next = '0;
        else if (tick)
            frame_cnt_next = frame_cnt + 16'd1;
        else
            frame_cnt_next = frame_cnt;
    end

    // Codes, enable and phase only move at the boundary; outputs come from next-state values.
    always_comb begin
        state_next = state;
        run_next   = run;
        act_next   = act;
        if (boundary) begin
            run_next = enable;
            for (int i = 0; i < 3; i++)
                act_next[i] = next_code(act[i], pos[i]);
            unique case (state)
                SYNC:    state_next = enable ? RUN : HOLD;
                RUN:     if (!enable) state_next = HOLD;
                HOLD:    if (enable) state_next = RUN;
                default: state_next = SYNC;
            endcase
        end
        for (int i = 0; i < 3; i++)
            pwm_next[i] = (state_next == RUN) && run_next &&
                          (frame_cnt_next < width_of(act_next[i]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            div_cnt     <= '0;
            frame_cnt   <= '0;
            act         <= {3{8'd128}};
            run         <= 1'b0;
            pwm         <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            div_cnt     <= div_cnt_next;
            frame_cnt   <= frame_cnt_next;
            act         <= act_next;
            run         <= run_next;
            pwm         <= pwm_next;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Scoreboard bench for servo_pwm_driver: random per-frame codes, expected high times queued per frame.
module tb_servo_pwm_driver;

    localparam int TICK_DIV  = 2;
    localparam int FRAME_US  = 300;
    localparam int MIN_US    = 50;
    localparam int STEP_US   = 1;
    localparam int SLEW_STEP = 4;
    localparam int FRAME_CYC = FRAME_US * TICK_DIV;
    localparam int NF        = 20;

    typedef struct packed {
        logic [2:0][31:0] hi;
    } frame_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] pos_x = 8'd128, pos_y = 8'd128, pos_z = 8'd128;
    logic       pwm_x, pwm_y, pwm_z, frame_start;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_act [3];
    frame_exp_t exp_q [$];

    servo_pwm_driver #(
        .TICK_DIV(TICK_DIV), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
        .STEP_US(STEP_US), .SLEW_STEP(SLEW_STEP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pos_x(pos_x), .pos_y(pos_y), .pos_z(pos_z),
        .pwm_x(pwm_x), .pwm_y(pwm_y), .pwm_z(pwm_z),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] px, input logic [7:0] py,
                                 input logic [7:0] pz);
        enable = en;
        pos_x  = px;
        pos_y  = py;
        pos_z  = pz;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [7:0] pickCode();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        if (r == 2) return 8'd249;
        return 8'($urandom_range(0, 255));
    endfunction

    // Reference: each boundary latches (or slews toward) the codes, width = MIN + code*STEP capped below the frame.
    task automatic modelBoundary(input logic en, input logic [7:0] px, input logic [7:0] py,
                                 input logic [7:0] pz);
        int target [3];
        int w;
        frame_exp_t e;
        target[0] = int'(px);
        target[1] = int'(py);
        target[2] = int'(pz);
        for (int ch = 0; ch < 3; ch++) begin
`ifdef SERVO_SLEW_LIMIT_EN
            if (target[ch] - model_act[ch] > SLEW_STEP)
                model_act[ch] = model_act[ch] + SLEW_STEP;
            else if (model_act[ch] - target[ch] > SLEW_STEP)
                model_act[ch] = model_act[ch] - SLEW_STEP;
            else
                model_act[ch] = target[ch];
`else
            model_act[ch] = target[ch];
`endif
            w = MIN_US + model_act[ch] * STEP_US;
            if (w > FRAME_US - 1) w = FRAME_US - 1;
            e.hi[ch] = en ? 32'(w * TICK_DIV) : 32'd0;
        end
        exp_q.push_back(e);
    endtask

    task automatic runFrames(input int n, input bit force_last_en);
        logic       en;
        logic [7:0] px, py, pz;
        int         base, fin;
        for (int k = 1; k <= n; k++) begin
            base = FRAME_CYC * (k - 1);
            waitCyc(base + int'($urandom_range(5, 300)));
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1)
                fin = FRAME_CYC * k - 1;
            else
                fin = base + int'($urandom_range(301, FRAME_CYC - 2));
            waitCyc(fin);
            en = ($urandom_range(0, 4) != 0);
            if (force_last_en && k == n) en = 1'b1;
            px = pickCode();
            py = pickCode();
            pz = pickCode();
            applyStimulus(en, px, py, pz);
            modelBoundary(en, px, py, pz);
        end
    endtask

    // Monitor: measures each frame between frame_start pulses and compares against the queue.
    int         idx = 0, last_start = 0;
    int         hcnt [3], rises [3];
    logic [2:0] prev = '0, start_val = '0;
    bit         timed_out = 0;

    task automatic finalizeFrame();
        frame_exp_t e;
        checkOutput("frame_period", idx - last_start, FRAME_CYC);
        if (exp_q.size() == 0) begin
            checkOutput("queue_nonempty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            for (int ch = 0; ch < 3; ch++) begin
                checkOutput($sformatf("high_cycles_ch%0d", ch), hcnt[ch], int'(e.hi[ch]));
                checkOutput($sformatf("pulse_count_ch%0d", ch), rises[ch], (e.hi[ch] != 0) ? 1 : 0);
                checkOutput($sformatf("start_level_ch%0d", ch), int'(start_val[ch]),
                            (e.hi[ch] != 0) ? 1 : 0);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] pw;
        if (!rst) begin
            idx = 0;
            last_start = 0;
            timed_out = 0;
            prev = '0;
            start_val = '0;
            for (int ch = 0; ch < 3; ch++) begin
                hcnt[ch] = 0;
                rises[ch] = 0;
            end
        end else begin
            idx++;
            pw = {pwm_z, pwm_y, pwm_x};
            if (frame_start) begin
                finalizeFrame();
                last_start = idx;
                timed_out = 0;
                prev = '0;
                start_val = pw;
                for (int ch = 0; ch < 3; ch++) begin
                    hcnt[ch] = 0;
                    rises[ch] = 0;
                end
            end else if (!timed_out && idx - last_start > FRAME_CYC + 50) begin
                checkOutput("frame_start_timeout", idx - last_start, FRAME_CYC);
                timed_out = 1;
            end
            for (int ch = 0; ch < 3; ch++) begin
                if (pw[ch]) hcnt[ch]++;
                if (pw[ch] && !prev[ch]) rises[ch]++;
            end
            prev = pw;
        end
    end

    initial begin
        frame_exp_t last;
        for (int ch = 0; ch < 3; ch++) model_act[ch] = 128;
        applyStimulus(1'b1, 8'd128, 8'd128, 8'd128);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_pwm", int'({pwm_z, pwm_y, pwm_x}), 0);
        checkOutput("reset_frame_start", int'(frame_start), 0);
        #1 rst = 1'b1;
        cyc = 0;
        exp_q.push_back('0);

        runFrames(NF, 1'b1);
        waitCyc(FRAME_CYC * NF + 30);
        last = exp_q[$];
        checkOutput("pre_reset_pwm_x", int'(pwm_x), (last.hi[0] > 30) ? 1 : 0);
        checkOutput("pre_reset_pwm_y", int'(pwm_y), (last.hi[1] > 30) ? 1 : 0);
        checkOutput("pre_reset_pwm_z", int'(pwm_z), (last.hi[2] > 30) ? 1 : 0);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_pwm", int'({pwm_z, pwm_y, pwm_x}), 0);
        checkOutput("async_reset_frame_start", int'(frame_start), 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        for (int ch = 0; ch < 3; ch++) model_act[ch] = 128;
        #2 rst = 1'b1;
        cyc = 0;
        exp_q.push_back('0);

        runFrames(3, 1'b0);
        waitCyc(FRAME_CYC * 4 + 5);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
